chacha_block_ctrl: RTL

Sequencer for the ChaCha20 keystream pipeline. It builds the 4x4 initial state from key, nonce and block counter, and issues 10 double-round requests to the external quarter-round datapath. It then performs the final feed-forward addition and hands each 512-bit keystream block to the downstream consumer over a valid/ready handshake. Counter increment and multi-block bursts run without software involvement, which keeps the round datapath busy between blocks.

---
 rtl/chacha_block_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/chacha_block_ctrl.sv
// chacha_block_ctrl
// Sequencer for one ChaCha20 keystream lane. Builds the 4x4 initial state,
// hands the working state to an external double-round datapath DR_COUNT
// times, adds the initial state back in (feed-forward), and presents the
// 512-bit keystream block on a valid/ready port. The counter advances and
// multi-block bursts repeat without software involvement.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   start             one-cycle request, honoured only while idle
//   key/nonce         256-bit key (state words 4..11), 96-bit nonce (13..15)
//   ctr_init          first block counter (state word 12)
//   num_blocks        blocks per burst, 0 behaves as 1
//   dr_start          one-cycle request to the round datapath
//   dr_state_in       state presented to the datapath, word i at [32i+31:32i]
//   dr_done           datapath result strobe, dr_state_out valid with it
//   dr_state_out      state after one column+diagonal double round
//   ks_valid/ks_ready keystream handshake
//   ks_data, ks_ctr   keystream block and the counter that produced it
//   busy              high whenever not idle
//   ctr_wrap          sticky flag, counter stepped past 0xFFFFFFFF
//
// state | meaning
// IDLE  | waiting for start, inputs captured on start
// LOAD  | build initial state from captured inputs, clear round count
// ISSUE | pulse dr_start with the working state
// WAIT  | wait for dr_done, absorb result, count the round
// ADD   | feed-forward add, capture keystream block and counter
// OUT   | offer block; on handshake advance counter and burst count

module chacha_block_ctrl #(
  parameter int DR_COUNT = 10,
  parameter int BLK_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [255:0]     key,
  input  logic [95:0]      nonce,
  input  logic [31:0]      ctr_init,
  input  logic [BLK_W-1:0] num_blocks,
  output logic             dr_start,
  output logic [511:0]     dr_state_in,
  input  logic             dr_done,
  input  logic [511:0]     dr_state_out,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [511:0]     ks_data,
  output logic [31:0]      ks_ctr,
  output logic             busy,
  output logic             ctr_wrap
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_ADD, S_OUT
  } state_t;

  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32,
                                    32'h3320646e, 32'h61707865};
  localparam logic [3:0]   DR_LAST = 4'(DR_COUNT - 1);

  state_t           state, state_nxt;
  logic [255:0]     key_r;
  logic [95:0]      nonce_r;
  logic [31:0]      ctr_r;
  logic [BLK_W-1:0] blk_left;
  logic [511:0]     init_reg, work_reg;
  logic [3:0]       dr_cnt;
  logic [511:0]     init_val, sum_val;
  logic             dr_last, blk_last;

  assign init_val    = {nonce_r, ctr_r, key_r, SIGMA};
  assign dr_last     = (dr_cnt == DR_LAST);
  assign blk_last    = (blk_left == BLK_W'(1));
  // work_reg only changes in LOAD and on an accepted dr_done, so it is
  // already stable for the whole ISSUE..dr_done window.
  assign dr_state_in = work_reg;

  // Per-word modular add; carries never cross word boundaries.
  always_comb begin
    sum_val = '0;
    for (int i = 0; i < 16; i++)
      sum_val[32*i +: 32] = work_reg[32*i +: 32] + init_reg[32*i +: 32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dr_start  = 1'b0;
    ks_valid  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: begin
        dr_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (dr_done) state_nxt = dr_last ? S_ADD : S_ISSUE;
      end
      S_ADD:   state_nxt = S_OUT;
      S_OUT: begin
        ks_valid = 1'b1;
        if (ks_ready) state_nxt = blk_last ? S_IDLE : S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r    <= '0;
      nonce_r  <= '0;
      ctr_r    <= '0;
      blk_left <= '0;
      init_reg <= '0;
      work_reg <= '0;
      dr_cnt   <= '0;
      ks_data  <= '0;
      ks_ctr   <= '0;
      ctr_wrap <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_r    <= key;
            nonce_r  <= nonce;
            ctr_r    <= ctr_init;
            blk_left <= (num_blocks == '0) ? BLK_W'(1) : num_blocks;
            ctr_wrap <= 1'b0;
          end
        end
        S_LOAD: begin
          init_reg <= init_val;
          work_reg <= init_val;
          dr_cnt   <= '0;
        end
        S_WAIT: begin
          if (dr_done) begin
            work_reg <= dr_state_out;
            dr_cnt   <= dr_cnt + 4'd1;
          end
        end
        S_ADD: begin
          ks_data <= sum_val;
          ks_ctr  <= ctr_r;
        end
        S_OUT: begin
          if (ks_ready) begin
            blk_left <= blk_left - BLK_W'(1);
            ctr_r    <= ctr_r + 32'd1;
            if (ctr_r == 32'hFFFF_FFFF) ctr_wrap <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
